mem_lsu: RTL and testbench

- MEM-stage load/store unit. Consumes the EX-stage memory fields (ALUOutput address, write_reg store data, mem_type, MemRead/MemWrite, rd/RegWrite/MemToReg, pc).
- Drives a single-outstanding req/ack data-memory port and stalls the pipeline while an access is pending.
- Delivers the aligned, sign/zero-extended load result and control fields to write-back.
- Acts as the consumer end of the ALU's mem_type/byte-lane encoding: 1=byte, 3=half, 15=word, 8=unsigned byte, 12=unsigned half, 0=invalid.

---
 rtl/mem_lsu_pkg.sv | 36 +++
 rtl/mem_lsu_if.sv | 20 ++
 rtl/mem_lsu_lane_align.sv | 53 +++++
 rtl/mem_lsu.sv | 176 +++++++++++++++++
 tb/tb_mem_lsu.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared lane codes, FSM state and write-back record for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam logic [3:0] MTYPE_INV = 4'd0;
  localparam logic [3:0] MTYPE_B   = 4'd1;
  localparam logic [3:0] MTYPE_H   = 4'd3;
  localparam logic [3:0] MTYPE_BU  = 4'd8;
  localparam logic [3:0] MTYPE_HU  = 4'd12;
  localparam logic [3:0] MTYPE_W   = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        regwrite;
    logic [31:0] data;
  } wb_t;

  // Codes outside the ALU's byte-lane set are treated as faults.
  function automatic logic mtype_aligned(input logic [3:0] mtype, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (mtype)
      MTYPE_B, MTYPE_BU: ok = 1'b1;
      MTYPE_H, MTYPE_HU: ok = ~lo[0];
      MTYPE_W:           ok = (lo == 2'b00);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Single-outstanding req/ack data-memory port between the LSU (master) and memory (slave).
interface mem_lsu_if;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    input  i_dmem_ack, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    output i_dmem_ack, i_dmem_rdata
  );
endinterface

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering: store enables/replicated data, and load lane select with extension.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  st_type_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [3:0]  ld_type_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rshift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = st_data_i;
    case (st_type_i)
      MTYPE_B, MTYPE_BU: begin
        be_o    = 4'b0001 << st_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      MTYPE_H, MTYPE_HU: begin
        be_o    = 4'b0011 << {st_lo_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      MTYPE_W: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  assign rshift  = rdata_i >> {ld_lo_i, 3'b000};
  assign ld_byte = rshift[7:0];
  assign ld_half = ld_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    ld_data_o = 32'h0;
    case (ld_type_i)
      MTYPE_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MTYPE_BU: ld_data_o = {24'h0, ld_byte};
      MTYPE_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MTYPE_HU: ld_data_o = {16'h0, ld_half};
      MTYPE_W:  ld_data_o = rdata_i;
      default:  ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: accepts EX fields, runs one req/ack access at a time while
// stalling upstream, and hands aligned/extended results to write-back.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_mem_type,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [4:0]  i_rd,
  input  logic        i_RegWrite,
  input  logic        i_MemToReg,
  output logic        o_stall,
  mem_lsu_if.master   dmem,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_pc,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_RegWrite,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam int unsigned CW      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  wb_t         cap_q, cap_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  mtype_q, mtype_d;
  logic        m2r_q, m2r_d;
  wb_t         wb_q, wb_d;
  logic        wb_valid_q, wb_valid_d;
  logic        misal_q, misal_d;
  logic        berr_q, berr_d;

  logic        memop, ok, to_hit, stall_c;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;

  mem_lane_align u_align (
    .st_type_i (i_mem_type),
    .st_lo_i   (i_addr[1:0]),
    .st_data_i (i_wdata),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_type_i (mtype_q),
    .ld_lo_i   (cap_q.data[1:0]),
    .rdata_i   (dmem.i_dmem_rdata),
    .ld_data_o (ld_ext)
  );

  assign memop = i_valid & (i_MemRead | i_MemWrite);
  assign ok    = mtype_aligned(i_mem_type, i_addr[1:0]);

  // Timeout fires in the BUSY cycle whose edge would bring the counter to TIMEOUT_CYC;
  // an ack in that same cycle takes priority.
  assign to_hit = (TIMEOUT_CYC != 0) && (state_q == BUSY) && !dmem.i_dmem_ack
                  && (cnt_q == CW'(TO_LAST));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    mtype_d    = mtype_q;
    m2r_d      = m2r_q;
    wb_d       = wb_q;
    wb_valid_d = 1'b0;
    misal_d    = 1'b0;
    berr_d     = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop && ok) begin
          state_d = BUSY;
          cnt_d   = '0;
          cap_d   = '{pc: i_pc, rd: i_rd, regwrite: i_RegWrite, data: i_addr};
          be_d    = st_be;
          wdata_d = st_wdata;
          we_d    = i_MemWrite;
          mtype_d = i_mem_type;
          m2r_d   = i_MemToReg;
          stall_c = 1'b1;
        end else if (memop) begin
          misal_d    = 1'b1;
          wb_valid_d = 1'b1;
          wb_d       = '{pc: i_pc, rd: i_rd, regwrite: 1'b0, data: i_addr};
        end else begin
          wb_valid_d = i_valid;
          wb_d       = '{pc: i_pc, rd: i_rd, regwrite: i_RegWrite, data: i_addr};
        end
      end
      BUSY: begin
        stall_c = ~dmem.i_dmem_ack & ~to_hit;
        if (dmem.i_dmem_ack) begin
          state_d     = IDLE;
          cnt_d       = '0;
          wb_valid_d  = 1'b1;
          wb_d        = cap_q;
          wb_d.regwrite = cap_q.regwrite & ~we_q;
          if (m2r_q) wb_d.data = ld_ext;
        end else if (to_hit) begin
          state_d     = IDLE;
          cnt_d       = '0;
          berr_d      = 1'b1;
          wb_valid_d  = 1'b1;
          wb_d        = cap_q;
          wb_d.regwrite = 1'b0;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      mtype_q    <= MTYPE_INV;
      m2r_q      <= 1'b0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      misal_q    <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      mtype_q    <= mtype_d;
      m2r_q      <= m2r_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      misal_q    <= misal_d;
      berr_q     <= berr_d;
    end
  end

  // Stall is combinational on the inputs, so it is forced low while reset is held.
  assign o_stall           = stall_c & i_reset;
  assign dmem.o_dmem_req   = (state_q == BUSY);
  assign dmem.o_dmem_we    = we_q;
  assign dmem.o_dmem_addr  = {cap_q.data[31:2], 2'b00};
  assign dmem.o_dmem_be    = be_q;
  assign dmem.o_dmem_wdata = wdata_q;

  assign o_wb_valid    = wb_valid_q;
  assign o_wb_pc       = wb_q.pc;
  assign o_wb_rd       = wb_q.rd;
  assign o_wb_RegWrite = wb_q.regwrite;
  assign o_wb_data     = wb_q.data;
  assign o_misaligned  = misal_q;
  assign o_bus_err     = berr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed plan cases plus randomized accesses
// against an arithmetic reference model; a second instance exercises a short timeout.
module tb_mem_lsu;

  logic        i_clk, i_reset, i_valid;
  logic [31:0] i_pc, i_addr, i_wdata;
  logic [3:0]  i_mem_type;
  logic        i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg;
  logic [4:0]  i_rd;

  logic        stall_a, wbv_a, rw_a, mis_a, berr_a;
  logic [31:0] wbpc_a, wbd_a;
  logic [4:0]  wbrd_a;
  logic        stall_b, wbv_b, rw_b, mis_b, berr_b;
  logic [31:0] wbpc_b, wbd_b;
  logic [4:0]  wbrd_b;

  int n_vec = 0;
  int n_err = 0;

  mem_lsu_if dmem_a ();
  mem_lsu_if dmem_b ();

  mem_lsu #(.TIMEOUT_CYC(255)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc(i_pc), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_mem_type(i_mem_type), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_rd(i_rd), .i_RegWrite(i_RegWrite), .i_MemToReg(i_MemToReg), .o_stall(stall_a),
    .dmem(dmem_a), .o_wb_valid(wbv_a), .o_wb_pc(wbpc_a), .o_wb_rd(wbrd_a),
    .o_wb_RegWrite(rw_a), .o_wb_data(wbd_a), .o_misaligned(mis_a), .o_bus_err(berr_a)
  );

  mem_lsu #(.TIMEOUT_CYC(4)) dut_to (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc(i_pc), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_mem_type(i_mem_type), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_rd(i_rd), .i_RegWrite(i_RegWrite), .i_MemToReg(i_MemToReg), .o_stall(stall_b),
    .dmem(dmem_b), .o_wb_valid(wbv_b), .o_wb_pc(wbpc_b), .o_wb_rd(wbrd_b),
    .o_wb_RegWrite(rw_b), .o_wb_data(wbd_b), .o_misaligned(mis_b), .o_bus_err(berr_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic int msize(input logic [3:0] t);
    if (t == 4'd1 || t == 4'd8)  return 1;
    if (t == 4'd3 || t == 4'd12) return 2;
    if (t == 4'd15)              return 4;
    return 0;
  endfunction

  function automatic logic m_ok(input logic [3:0] t, input logic [31:0] a);
    int sz;
    sz = msize(t);
    return (sz != 0) && ((a % sz) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] t, input logic [31:0] a);
    int sz;
    sz = msize(t);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] t, input logic [31:0] d);
    int sz;
    sz = msize(t);
    if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] t, input logic [31:0] a, input logic [31:0] r);
    int sz;
    longint mask;
    logic [31:0] v;
    sz = msize(t);
    if (sz == 4) return r;
    mask = (longint'(1) << (8 * sz)) - 1;
    v = 32'((longint'(r) >> (8 * (a % 4))) & mask);
    if ((t == 4'd1 || t == 4'd3) && v[8 * sz - 1]) v = v | ~32'(mask);
    return v;
  endfunction

  // ---------------- tasks ----------------
  task automatic drive_idle();
    i_valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    drive_idle();
    i_pc = '0; i_addr = '0; i_wdata = '0; i_mem_type = '0; i_rd = '0;
    i_RegWrite = 1'b0; i_MemToReg = 1'b0;
    dmem_a.i_dmem_ack = 1'b0; dmem_a.i_dmem_rdata = '0;
    dmem_b.i_dmem_ack = 1'b0; dmem_b.i_dmem_rdata = '0;
    #2;
    n_vec++; if (stall_a !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall_a); end
    n_vec++; if (dmem_a.o_dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b exp=0", dmem_a.o_dmem_req); end
    n_vec++; if (wbv_a !== 1'b0) begin n_err++; $display("FAIL reset_wbv got=%0b exp=0", wbv_a); end
    n_vec++; if ({mis_a, berr_a, rw_a} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {mis_a, berr_a, rw_a}); end
    n_vec++; if (wbd_a !== 32'h0) begin n_err++; $display("FAIL reset_wbdata got=%h exp=0", wbd_a); end
    n_vec++; if (dmem_a.o_dmem_be !== 4'h0) begin n_err++; $display("FAIL reset_be got=%b exp=0000", dmem_a.o_dmem_be); end
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  // Caller is at (or just after) a negedge; returns just after a negedge with valid dropped.
  task automatic do_access(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                           input logic wr, input logic rw, input logic m2r, input int dly,
                           input logic [31:0] rdat, input string tag);
    logic ok; logic [31:0] pc_e, data_e; logic [4:0] rd_e; logic rw_e; int stalls;
    ok = m_ok(t, a);
    i_valid = 1'b1; i_pc = $urandom; i_addr = a; i_wdata = d; i_mem_type = t;
    i_MemRead = ~wr; i_MemWrite = wr; i_rd = 5'($urandom_range(0, 31));
    i_RegWrite = rw; i_MemToReg = m2r;
    pc_e = i_pc; rd_e = i_rd;
    #1;
    n_vec++; if (stall_a !== ok) begin n_err++; $display("FAIL %s stall_accept got=%0b exp=%0b", tag, stall_a, ok); end
    stalls = int'(stall_a);
    @(posedge i_clk); @(negedge i_clk);
    if (!ok) begin
      drive_idle();
      #1;
      n_vec++; if (dmem_a.o_dmem_req !== 1'b0) begin n_err++; $display("FAIL %s mis_req got=%0b exp=0", tag, dmem_a.o_dmem_req); end
      n_vec++; if ({wbv_a, rw_a, mis_a} !== 3'b101) begin n_err++; $display("FAIL %s mis_wb got=%b exp=101", tag, {wbv_a, rw_a, mis_a}); end
      n_vec++; if (wbpc_a !== pc_e) begin n_err++; $display("FAIL %s mis_pc got=%h exp=%h", tag, wbpc_a, pc_e); end
      @(posedge i_clk); @(negedge i_clk); #1;
      n_vec++; if (mis_a !== 1'b0) begin n_err++; $display("FAIL %s mis_pulse got=%0b exp=0", tag, mis_a); end
      return;
    end
    for (int k = 0; k <= dly; k++) begin
      if (k > 0) begin @(posedge i_clk); @(negedge i_clk); end
      n_vec++; if (dmem_a.o_dmem_req !== 1'b1) begin n_err++; $display("FAIL %s req[%0d] got=%0b exp=1", tag, k, dmem_a.o_dmem_req); end
      n_vec++; if (dmem_a.o_dmem_addr !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL %s addr[%0d] got=%h exp=%h", tag, k, dmem_a.o_dmem_addr, {a[31:2], 2'b00}); end
      n_vec++; if (dmem_a.o_dmem_be !== m_be(t, a)) begin n_err++; $display("FAIL %s be[%0d] got=%b exp=%b", tag, k, dmem_a.o_dmem_be, m_be(t, a)); end
      n_vec++; if (dmem_a.o_dmem_we !== wr) begin n_err++; $display("FAIL %s we[%0d] got=%0b exp=%0b", tag, k, dmem_a.o_dmem_we, wr); end
      if (wr) begin
        n_vec++; if (dmem_a.o_dmem_wdata !== m_wdata(t, d)) begin n_err++; $display("FAIL %s wdata got=%h exp=%h", tag, dmem_a.o_dmem_wdata, m_wdata(t, d)); end
      end
      if (k == dly) begin dmem_a.i_dmem_ack = 1'b1; dmem_a.i_dmem_rdata = rdat; end
      #1;
      stalls += int'(stall_a);
    end
    @(posedge i_clk); @(negedge i_clk);
    dmem_a.i_dmem_ack = 1'b0; dmem_a.i_dmem_rdata = $urandom;
    drive_idle();
    #1;
    rw_e = rw & ~wr;
    data_e = m2r ? m_load(t, a, rdat) : a;
    n_vec++; if (stalls != dly + 1) begin n_err++; $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, stalls, dly + 1); end
    n_vec++; if (wbv_a !== 1'b1) begin n_err++; $display("FAIL %s wb_valid got=%0b exp=1", tag, wbv_a); end
    n_vec++; if (rw_a !== rw_e) begin n_err++; $display("FAIL %s wb_regwrite got=%0b exp=%0b", tag, rw_a, rw_e); end
    n_vec++; if (wbd_a !== data_e) begin n_err++; $display("FAIL %s wb_data got=%h exp=%h", tag, wbd_a, data_e); end
    n_vec++; if ({wbpc_a, wbrd_a} !== {pc_e, rd_e}) begin n_err++; $display("FAIL %s wb_pc_rd got=%h/%0d exp=%h/%0d", tag, wbpc_a, wbrd_a, pc_e, rd_e); end
    n_vec++; if (dmem_a.o_dmem_req !== 1'b0) begin n_err++; $display("FAIL %s req_after got=%0b exp=0", tag, dmem_a.o_dmem_req); end
  endtask

  task automatic do_pass(input logic v, input string tag);
    logic [31:0] pc_e, a_e; logic [4:0] rd_e; logic rw_e;
    i_valid = v; i_MemRead = 1'b0; i_MemWrite = 1'b0;
    i_pc = $urandom; i_addr = $urandom; i_rd = 5'($urandom_range(0, 31));
    i_RegWrite = 1'($urandom_range(0, 1)); i_MemToReg = 1'($urandom_range(0, 1));
    pc_e = i_pc; a_e = i_addr; rd_e = i_rd; rw_e = i_RegWrite;
    #1;
    n_vec++; if (stall_a !== 1'b0) begin n_err++; $display("FAIL %s stall got=%0b exp=0", tag, stall_a); end
    @(posedge i_clk); @(negedge i_clk); #1;
    n_vec++; if (wbv_a !== v) begin n_err++; $display("FAIL %s wb_valid got=%0b exp=%0b", tag, wbv_a, v); end
    n_vec++; if ({wbd_a, wbpc_a, wbrd_a, rw_a} !== {a_e, pc_e, rd_e, rw_e})
      begin n_err++; $display("FAIL %s wb_fields got=%h/%h/%0d/%0b exp=%h/%h/%0d/%0b", tag, wbd_a, wbpc_a, wbrd_a, rw_a, a_e, pc_e, rd_e, rw_e); end
  endtask

  task automatic test_directed();
    @(negedge i_clk);
    do_access(4'd1,  32'h0000_0103, 32'h0, 1'b0, 1'b1, 1'b1, 1, 32'h8000_0000, "lb_103");
    n_vec++; if (wbd_a !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_103_value got=%h exp=ffffff80", wbd_a); end
    do_access(4'd3,  32'h0000_0202, 32'h1234_ABCD, 1'b1, 1'b1, 1'b0, 0, 32'h0, "sh_202");
    do_access(4'd12, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b1, 5, 32'h0000_F00D, "lhu_10");
    do_access(4'd15, 32'h0000_0006, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'h0, "lw_mis");
    do_access(4'd0,  32'h0000_0008, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'h0, "type0");
    do_access(4'd8,  32'h0000_0021, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'hA5F0_C3E1, "lbu_21");
    do_access(4'd3,  32'h0000_0032, 32'h0, 1'b0, 1'b1, 1'b1, 2, 32'h8001_7FFF, "lh_32");
    do_access(4'd3,  32'h0000_0033, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'h0, "lh_mis");
    do_access(4'd1,  32'h0000_0041, 32'hCAFE_0077, 1'b1, 1'b1, 1'b0, 1, 32'h0, "sb_41");
  endtask

  task automatic test_random();
    logic [3:0] types [6] = '{4'd0, 4'd1, 4'd3, 4'd8, 4'd12, 4'd15};
    logic [3:0] t; logic [31:0] a; logic wr;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_pass(1'($urandom_range(0, 1)), "rnd_pass");
      end else begin
        t = types[$urandom_range(0, 5)];
        a = $urandom;
        wr = 1'($urandom_range(0, 1));
        do_access(t, a, $urandom, wr, 1'($urandom_range(0, 1)), wr ? 1'b0 : 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom, "rnd_mem");
      end
    end
  endtask

  task automatic test_back_to_back();
    do_pass(1'b1, "b2b_pass0");
    do_access(4'd15, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'hDEAD_BEEF, "b2b_lw");
    do_access(4'd15, 32'h0000_1004, 32'h1357_9BDF, 1'b1, 1'b1, 1'b0, 0, 32'h0, "b2b_sw");
    do_pass(1'b1, "b2b_pass1");
    do_pass(1'b0, "b2b_bubble");
  endtask

  task automatic test_reset_busy();
    @(negedge i_clk);
    i_valid = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_mem_type = 4'd15;
    i_addr = 32'h0000_0200; i_RegWrite = 1'b1; i_MemToReg = 1'b1;
    @(posedge i_clk); @(negedge i_clk); #1;
    n_vec++; if (dmem_a.o_dmem_req !== 1'b1) begin n_err++; $display("FAIL rstbusy_req_pre got=%0b exp=1", dmem_a.o_dmem_req); end
    #1 i_reset = 1'b0;
    #1;
    n_vec++; if (dmem_a.o_dmem_req !== 1'b0) begin n_err++; $display("FAIL rstbusy_req_drop got=%0b exp=0", dmem_a.o_dmem_req); end
    n_vec++; if (stall_a !== 1'b0) begin n_err++; $display("FAIL rstbusy_stall got=%0b exp=0", stall_a); end
    drive_idle();
    @(negedge i_clk);
    i_reset = 1'b1;
    dmem_a.i_dmem_ack = 1'b1; dmem_a.i_dmem_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); @(negedge i_clk); #1;
      n_vec++; if ({wbv_a, dmem_a.o_dmem_req} !== 2'b00) begin n_err++; $display("FAIL rstbusy_late_ack[%0d] got=%b exp=00", k, {wbv_a, dmem_a.o_dmem_req}); end
    end
    dmem_a.i_dmem_ack = 1'b0;
    do_access(4'd1, 32'h0000_0300, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_007F, "post_rst_lb");
  endtask

  task automatic test_timeout();
    repeat (8) @(negedge i_clk);
    for (int run = 0; run < 2; run++) begin
      i_valid = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_mem_type = 4'd12;
      i_addr = 32'h0000_0042; i_RegWrite = 1'b1; i_MemToReg = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin @(posedge i_clk); @(negedge i_clk); end
        if (run == 1 && k == 3) begin dmem_b.i_dmem_ack = 1'b1; dmem_b.i_dmem_rdata = 32'h9ABC_0000; end
        #1;
        n_vec++; if (dmem_b.o_dmem_req !== 1'b1) begin n_err++; $display("FAIL to%0d_req[%0d] got=%0b exp=1", run, k, dmem_b.o_dmem_req); end
        n_vec++; if (stall_b !== (k < 3)) begin n_err++; $display("FAIL to%0d_stall[%0d] got=%0b exp=%0b", run, k, stall_b, k < 3); end
      end
      @(posedge i_clk); @(negedge i_clk);
      dmem_b.i_dmem_ack = 1'b0;
      drive_idle();
      #1;
      n_vec++; if (dmem_b.o_dmem_req !== 1'b0) begin n_err++; $display("FAIL to%0d_req_after got=%0b exp=0", run, dmem_b.o_dmem_req); end
      n_vec++; if (berr_b !== (run == 0)) begin n_err++; $display("FAIL to%0d_bus_err got=%0b exp=%0b", run, berr_b, run == 0); end
      n_vec++; if ({wbv_b, rw_b} !== {1'b1, run == 1}) begin n_err++; $display("FAIL to%0d_wb got=%b exp=%b", run, {wbv_b, rw_b}, {1'b1, run == 1}); end
      if (run == 1) begin
        n_vec++; if (wbd_b !== 32'h0000_9ABC) begin n_err++; $display("FAIL to1_data got=%h exp=00009abc", wbd_b); end
      end
      @(posedge i_clk); @(negedge i_clk); #1;
      n_vec++; if (berr_b !== 1'b0) begin n_err++; $display("FAIL to%0d_bus_err_pulse got=%0b exp=0", run, berr_b); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_busy();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
